// File: rtl/bus_cmd_master_pkg.sv
// Shared types and constants for the single-beat bus command master.
// Trans encodings, FSM states and the command/response bundles.
package bus_cmd_master_pkg;

  localparam int addr_w_c = 32;
  localparam int data_w_c = 32;

  localparam logic [1:0] trans_idle_c   = 2'b00;
  localparam logic [1:0] trans_nonseq_c = 2'b10;

  typedef enum logic [1:0] {
    st_idle,
    st_addr,
    st_data,
    st_rsp
  } state_e;

  typedef struct packed {
    logic [addr_w_c-1:0] addr;
    logic                write;
    logic [data_w_c-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic                err;
    logic                timeout;
    logic [data_w_c-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/bus_cmd_master.sv
// Single-outstanding bus master: accepts one command, runs an
// address/data transfer with wait-state timeout, holds the response.
module bus_cmd_master
  import bus_cmd_master_pkg::*;
#(
  parameter int unsigned timeout_p = 255
) (
  input  logic                main_clk_i,
  input  logic                main_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_accept_o,
  input  logic [addr_w_c-1:0] cmd_addr_i,
  input  logic                cmd_write_i,
  input  logic [data_w_c-1:0] cmd_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_accept_i,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,
  output logic [data_w_c-1:0] rsp_rdata_o,
  output logic [1:0]          bus_trans_o,
  output logic [addr_w_c-1:0] bus_addr_o,
  output logic                bus_write_o,
  output logic [data_w_c-1:0] bus_wdata_o,
  input  logic                bus_ready_i,
  input  logic                bus_resp_i,
  input  logic [data_w_c-1:0] bus_rdata_i,
  output logic                busy_o
);

  localparam logic [15:0] tmo_c    = 16'(timeout_p);
  localparam logic        tmo_en_c = (timeout_p != 0);

  state_e      state_q, state_d;
  cmd_t        cmd_q;
  rsp_t        rsp_q, rsp_d;
  logic [15:0] wait_q, wait_d, wait_inc;
  logic        rst_q;
  logic        cmd_fire;

  // rst_q keeps accept low in the cycle right after a reset edge
  assign cmd_accept_o = (state_q == st_idle) && !rst_q;
  assign cmd_fire     = cmd_valid_i && cmd_accept_o;
  assign wait_inc     = (wait_q == 16'hFFFF) ? wait_q
                                             : wait_q + 16'd1;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      st_idle: begin
        if (cmd_fire) begin
          state_d = st_addr;
          wait_d  = '0;
        end
      end
      st_addr: begin
        state_d = st_data;
      end
      st_data: begin
        if (bus_ready_i) begin
          rsp_d.err     = bus_resp_i;
          rsp_d.timeout = 1'b0;
          rsp_d.rdata   = (cmd_q.write || bus_resp_i) ? '0
                                                      : bus_rdata_i;
          state_d       = st_rsp;
        end else begin
          wait_d = wait_inc;
          if (tmo_en_c && (wait_inc >= tmo_c)) begin
            rsp_d.err     = 1'b1;
            rsp_d.timeout = 1'b1;
            rsp_d.rdata   = '0;
            state_d       = st_rsp;
          end
        end
      end
      st_rsp: begin
        if (rsp_accept_i) begin
          state_d = st_idle;
          rsp_d   = '0;
        end
      end
      default: begin
        state_d = st_idle;
      end
    endcase
  end

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q <= st_idle;
      cmd_q   <= '0;
      rsp_q   <= '0;
      wait_q  <= '0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      wait_q  <= wait_d;
      rst_q   <= 1'b0;
      if (cmd_fire) begin
        cmd_q.addr  <= cmd_addr_i;
        cmd_q.write <= cmd_write_i;
        cmd_q.wdata <= cmd_wdata_i;
      end
    end
  end

  assign bus_trans_o   = (state_q == st_addr) ? trans_nonseq_c
                                              : trans_idle_c;
  assign bus_addr_o    = cmd_q.addr;
  assign bus_write_o   = cmd_q.write;
  assign bus_wdata_o   = cmd_q.wdata;
  assign rsp_valid_o   = (state_q == st_rsp);
  assign rsp_err_o     = rsp_q.err;
  assign rsp_timeout_o = rsp_q.timeout;
  assign rsp_rdata_o   = rsp_q.rdata;
  assign busy_o        = (state_q != st_idle);

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed bench for bus_cmd_master with timeout_p = 4.
// Expected values are hand-derived per transfer.
module tb_bus_cmd_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_accept;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_accept;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  bus_trans;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_resp;
  logic [31:0] bus_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  bus_cmd_master #(.timeout_p(4)) dut (
    .main_clk_i    (clk),
    .main_rst_i    (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_accept_o  (cmd_accept),
    .cmd_addr_i    (cmd_addr),
    .cmd_write_i   (cmd_write),
    .cmd_wdata_i   (cmd_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_accept_i  (rsp_accept),
    .rsp_err_o     (rsp_err),
    .rsp_timeout_o (rsp_timeout),
    .rsp_rdata_o   (rsp_rdata),
    .bus_trans_o   (bus_trans),
    .bus_addr_o    (bus_addr),
    .bus_write_o   (bus_write),
    .bus_wdata_o   (bus_wdata),
    .bus_ready_i   (bus_ready),
    .bus_resp_i    (bus_resp),
    .bus_rdata_i   (bus_rdata),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // waits = ready-low DATA cycles before ready; >=40 means never
  task automatic xfer(input logic [31:0] a,
                      input logic        w,
                      input logic [31:0] wd,
                      input int          waits,
                      input logic        rs,
                      input logic [31:0] rd,
                      input logic        e_err,
                      input logic        e_tmo,
                      input logic [31:0] e_rd,
                      input int          e_lat,
                      input int          bp);
    int lat;
    int k;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    check("cmd_acc", {31'd0, cmd_accept}, 32'd1);
    step();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hDEAD_BEEF;
    cmd_wdata = 32'hBAD0_BAD0;
    lat = 1;
    check("nonseq", {30'd0, bus_trans}, 32'd2);
    check("addr", bus_addr, a);
    check("write", {31'd0, bus_write}, {31'd0, w});
    check("wdata_addr", bus_wdata, wd);
    check("busy_addr", {31'd0, busy}, 32'd1);
    step();
    lat++;
    k = 0;
    while (!rsp_valid && lat < 40) begin
      bus_ready = (k == waits);
      bus_resp  = rs;
      bus_rdata = rd;
      check("trans_data", {30'd0, bus_trans}, 32'd0);
      check("wdata_data", bus_wdata, wd);
      check("addr_data", bus_addr, a);
      k++;
      step();
      lat++;
    end
    bus_ready = 1'b0;
    bus_resp  = 1'b0;
    bus_rdata = 32'h0;
    check("rsp_lat", lat, e_lat);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
    check("rsp_tmo", {31'd0, rsp_timeout}, {31'd0, e_tmo});
    check("rsp_rdata", rsp_rdata, e_rd);
    check("acc_rsp", {31'd0, cmd_accept}, 32'd0);
    check("trans_rsp", {30'd0, bus_trans}, 32'd0);
    for (int i = 0; i < bp; i++) begin
      rsp_accept = 1'b0;
      step();
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_err", {31'd0, rsp_err}, {31'd0, e_err});
      check("bp_rdata", rsp_rdata, e_rd);
      check("bp_acc", {31'd0, cmd_accept}, 32'd0);
      check("bp_addr", bus_addr, a);
    end
    rsp_accept = 1'b1;
    step();
    rsp_accept = 1'b0;
    check("post_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_acc", {31'd0, cmd_accept}, 32'd1);
    check("post_addr", bus_addr, a);
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_write  = 1'b0;
    cmd_wdata  = '0;
    rsp_accept = 1'b0;
    bus_ready  = 1'b0;
    bus_resp   = 1'b0;
    bus_rdata  = '0;
    step();
    step();
    check("rst_acc", {31'd0, cmd_accept}, 32'd0);
    check("rst_trans", {30'd0, bus_trans}, 32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    step();
    check("rel_acc", {31'd0, cmd_accept}, 32'd1);

    // read, zero waits
    xfer(32'h0000_0010, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_F00D,
         1'b0, 1'b0, 32'hCAFE_F00D, 3, 0);
    // write, 3 waits: rdata forced to 0
    xfer(32'h0000_0020, 1'b1, 32'h1234_5678, 3, 1'b0, 32'h5555_AAAA,
         1'b0, 1'b0, 32'h0, 6, 0);
    // slave error on read
    xfer(32'h0000_0030, 1'b0, 32'h0, 1, 1'b1, 32'hFFFF_FFFF,
         1'b1, 1'b0, 32'h0, 4, 0);
    // timeout after 4 ready-low cycles
    xfer(32'h0000_0040, 1'b0, 32'h0, 99, 1'b0, 32'h7777_7777,
         1'b1, 1'b1, 32'h0, 6, 0);
    // ready on the 4th wait cycle wins over timeout
    xfer(32'h0000_0050, 1'b0, 32'h0, 3, 1'b0, 32'hA5A5_0001,
         1'b0, 1'b0, 32'hA5A5_0001, 6, 0);
    // response backpressure for 5 cycles
    xfer(32'h0000_0060, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_F00D,
         1'b0, 1'b0, 32'h0BAD_F00D, 3, 5);
    // back-to-back write right after backpressured accept
    xfer(32'h0000_0070, 1'b1, 32'hFEED_0001, 2, 1'b0, 32'h0,
         1'b0, 1'b0, 32'h0, 5, 0);

    // reset in DATA after two waits
    cmd_addr  = 32'h0000_0080;
    cmd_write = 1'b0;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("r_nonseq", {30'd0, bus_trans}, 32'd2);
    step();
    step();
    check("r_busy_data", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    check("r_trans", {30'd0, bus_trans}, 32'd0);
    check("r_busy", {31'd0, busy}, 32'd0);
    check("r_valid", {31'd0, rsp_valid}, 32'd0);
    check("r_acc", {31'd0, cmd_accept}, 32'd0);
    check("r_addr", bus_addr, 32'd0);
    rst       = 1'b0;
    bus_ready = 1'b1;
    bus_rdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      step();
      check("r_stale", {31'd0, rsp_valid}, 32'd0);
      check("r_idle", {31'd0, busy}, 32'd0);
    end
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    check("r_acc_rel", {31'd0, cmd_accept}, 32'd1);
    // counter starts clean: 3 waits must not time out
    xfer(32'h0000_0090, 1'b0, 32'h0, 3, 1'b0, 32'h0000_9999,
         1'b0, 1'b0, 32'h0000_9999, 6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_cmd_master.md
BUS_CMD_MASTER -- requirements
Module: bus_cmd_master

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have one parameter: timeout_p, default 255, data-phase wait-state limit (0 = timeout disabled, legal range 0..65535).
REQ-003 main_clk_i  in  1  clock, all logic on rising edge.
REQ-004 main_rst_i  in  1  synchronous active-high reset.
REQ-005 cmd_valid_i  in  1  command offered.
REQ-006 cmd_accept_o  out  1  command taken when high together with cmd_valid_i.
REQ-007 cmd_addr_i  in  32  transfer address.
REQ-008 cmd_write_i  in  1  1 = write, 0 = read.
REQ-009 cmd_wdata_i  in  32  write data.
REQ-010 rsp_valid_o  out  1  response available.
REQ-011 rsp_accept_i  in  1  response consumed when high together with rsp_valid_o.
REQ-012 rsp_err_o  out  1  slave error or timeout.
REQ-013 rsp_timeout_o  out  1  transfer aborted by timeout.
REQ-014 rsp_rdata_o  out  32  read data.
REQ-015 bus_trans_o, bus_addr_o, bus_write_o, bus_wdata_o  out  2/32/1/32  downstream bus request, consumed by the bus_i port group of the adjacent block.
REQ-016 bus_ready_i, bus_resp_i, bus_rdata_i  in  1/1/32  downstream bus response (1 = error on resp).
REQ-017 busy_o  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ADDR, DATA and RSP.
REQ-019 Transition IDLE->ADDR SHALL occur on cmd_valid_i & cmd_accept_o; cmd_addr_i, cmd_write_i and cmd_wdata_i are registered on that edge.
REQ-020 cmd_accept_o SHALL be high only in IDLE, with no combinational path from cmd_valid_i.
REQ-021 ADDR SHALL last exactly one cycle with bus_trans_o = NONSEQ (2'b10); in every other state bus_trans_o SHALL be IDLE (2'b00).
REQ-022 bus_addr_o, bus_write_o and bus_wdata_o SHALL reflect the registered command, hold stable through ADDR and DATA, and hold until the next accepted command.
REQ-023 DATA SHALL sample bus_ready_i every cycle; on ready=1 the FSM SHALL capture resp and rdata (rdata forced to 0 for writes or when resp=1) and go to RSP.
REQ-024 In DATA, a 16-bit wait counter SHALL increment on each ready=0 cycle; when timeout_p != 0 and the count reaches timeout_p, the FSM SHALL go to RSP with rsp_err_o=1, rsp_timeout_o=1 and rsp_rdata_o=0.
REQ-025 The wait counter SHALL clear on entry to ADDR and SHALL saturate at 0xFFFF, never wrapping.
REQ-026 If ready=1 arrives in the same cycle the count reaches timeout_p, the completed transfer SHALL win and no timeout is flagged.
REQ-027 In RSP, rsp_valid_o SHALL be 1 and its payload SHALL be stable until rsp_accept_i; on accept the FSM returns to IDLE, and the next command is accepted no earlier than the following cycle.
REQ-028 Latency: command accept at cycle N gives NONSEQ at N+1; with zero wait states, ready is sampled at N+2 and rsp_valid_o goes high at N+3.

Reset
REQ-029 While main_rst_i is high at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0, except cmd_accept_o which is 0 during reset and 1 from the first cycle after release.
REQ-030 Reset mid-transfer SHALL abandon the transfer with no response, bus_trans_o=0 from the next cycle, and the counter cleared.

Structure
REQ-031 A shared package bus_cmd_master_pkg SHALL hold: the trans encoding constants (IDLE 2'b00, NONSEQ 2'b10), the FSM state enum, and the address/data width constants (32).
REQ-032 No sub-module is required; the FSM, command register and wait counter SHALL be inline, targeting roughly 150-250 lines.

Verification
REQ-033 Read, zero waits: cmd addr=0x0000_0010 read; slave ready=1, rdata=0xCAFE_F00D -> NONSEQ at N+1, rsp_valid at N+3, rdata=0xCAFE_F00D, err=0.
REQ-034 Write with 3 wait states: addr=0x20, wdata=0x1234_5678 -> bus_wdata_o stable 4 DATA cycles, rsp_valid at N+6, rdata=0, err=0.
REQ-035 Slave error on read (resp=1, rdata=0xFFFF_FFFF) -> rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=0.
REQ-036 Timeout: timeout_p=4, ready held 0 -> RSP after 4 DATA cycles with err=1, timeout=1; second case with ready=1 on the 4th wait cycle -> no timeout.
REQ-037 Backpressure: rsp_accept_i held 0 for 5 cycles -> payload stable, cmd_accept_o=0 throughout, new command accepted the cycle after rsp accept.
REQ-038 Reset asserted in DATA -> next cycle bus_trans_o=0, busy_o=0, rsp_valid_o=0, and no stale response after reset release.
